double_pulse_gen: RTL and testbench

// - Transmit end of the calc double-pulse protocol: drives line a_out with HIGH, LOW, HIGH, LOW

---
 rtl/double_pulse_gen_pkg.sv | 21 ++
 rtl/double_pulse_gen_phase_timer.sv | 30 +++
 rtl/double_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_double_pulse_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/double_pulse_gen_pkg.sv
// Shared definitions for the double-pulse transmitter: state encodings,
// default widths and the per-state line level.
package double_pulse_gen_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int GAP_MIN_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI1  = 3'd1,
    ST_LO1  = 3'd2,
    ST_HI2  = 3'd3,
    ST_LO2  = 3'd4
  } state_t;

  // Line level driven while in a given state.
  function automatic logic state_level(input state_t s);
    return (s == ST_HI1) || (s == ST_HI2);
  endfunction

endpackage

// File: rtl/double_pulse_gen_phase_timer.sv
// Loadable down-counter timing one protocol phase; expired flags a count of zero.
// It holds at zero rather than wrapping, so an idle timer always reads expired.
module double_pulse_gen_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_clr,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/double_pulse_gen.sv
// Double-pulse transmitter: drives HIGH, LOW, HIGH, LOW phases of programmable
// width on o_a_out per accepted start, with busy/done handshake and abort.
//
// state | meaning
// IDLE  | waiting for start; line low
// HI1   | first HIGH phase, hi cycles
// LO1   | separating LOW phase, lo cycles
// HI2   | second HIGH phase, hi cycles
// LO2   | trailing LOW, max(lo, GAP_MIN) cycles; done on exit
module double_pulse_gen
  import double_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_MIN = GAP_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_hi_len,
  input  logic [CNT_W-1:0] i_lo_len,
  output logic             o_a_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP = CNT_W'(GAP_MIN);

  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? ONE : len;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hi_len;
  logic [CNT_W-1:0] r_lo_len;
  logic [CNT_W-1:0] r_trail_len;
  logic [CNT_W-1:0] w_hi_eff;
  logic [CNT_W-1:0] w_lo_eff;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_clr;
  logic             w_expired;
  logic             w_done_nxt;
  logic             r_a_out;
  logic             r_busy;
  logic             r_done;

  assign w_hi_eff = eff_len(i_hi_len);
  assign w_lo_eff = eff_len(i_lo_len);
  // Abort beats start in IDLE, so an abort/start pair never launches a pattern.
  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;

  double_pulse_gen_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_clr      (w_clr),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_len    <= '0;
      r_lo_len    <= '0;
      r_trail_len <= '0;
    end else if (w_accept) begin
      r_hi_len    <= w_hi_eff;
      r_lo_len    <= w_lo_eff;
      r_trail_len <= (w_lo_eff > GAP) ? w_lo_eff : GAP;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_clr       = 1'b0;
    w_done_nxt  = 1'b0;
    if ((r_state != ST_IDLE) && i_abort) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ST_HI1;
            w_load      = 1'b1;
            w_load_val  = w_hi_eff - ONE;
          end
        end
        ST_HI1: begin
          if (w_expired) begin
            w_state_nxt = ST_LO1;
            w_load      = 1'b1;
            w_load_val  = r_lo_len - ONE;
          end
        end
        ST_LO1: begin
          if (w_expired) begin
            w_state_nxt = ST_HI2;
            w_load      = 1'b1;
            w_load_val  = r_hi_len - ONE;
          end
        end
        ST_HI2: begin
          if (w_expired) begin
            w_state_nxt = ST_LO2;
            w_load      = 1'b1;
            w_load_val  = r_trail_len - ONE;
          end
        end
        ST_LO2: begin
          if (w_expired) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  // Outputs are registered copies of what the next state implies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_out <= state_level(w_state_nxt);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign o_a_out = r_a_out;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_double_pulse_gen.sv
// Scoreboard bench for double_pulse_gen: the driver predicts each accepted
// pattern, the monitor captures the line while busy and checks it at pattern end.
module tb_double_pulse_gen;

  localparam int CNT_W   = 8;
  localparam int GAP_MIN = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             i_abort;
  logic [CNT_W-1:0] i_hi_len;
  logic [CNT_W-1:0] i_lo_len;
  logic             o_a_out;
  logic             o_busy;
  logic             o_done;

  double_pulse_gen #(.CNT_W(CNT_W), .GAP_MIN(GAP_MIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_abort  (i_abort),
    .i_hi_len (i_hi_len),
    .i_lo_len (i_lo_len),
    .o_a_out  (o_a_out),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;        // edge after which start was driven
    int hi;
    int lo;
    int tr;
    bit aborted;
    int abort_k;  // edge after which abort was driven
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_active = 0;
  int   m_end = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int total_len(input rec_t r);
    return 2 * r.hi + r.lo + r.tr;
  endfunction

  // Protocol waveform: hi ones, lo zeros, hi ones, trailing zeros.
  function automatic bit wave_bit(input rec_t r, input int i);
    if (i < r.hi) return 1'b1;
    if (i < r.hi + r.lo) return 1'b0;
    if (i < 2 * r.hi + r.lo) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs just after a rising edge and update the model.
  task automatic step(input bit s, input bit a, input int h, input int l);
    rec_t r;
    int   k;
    @(posedge clk);
    #1;
    k        = cyc;
    i_start  = s;
    i_abort  = a;
    i_hi_len = CNT_W'(h);
    i_lo_len = CNT_W'(l);
    if (!m_active || k >= m_end) begin
      m_active = 0;
      if (s && !a) begin
        r.t       = k;
        r.hi      = (h == 0) ? 1 : h;
        r.lo      = (l == 0) ? 1 : l;
        r.tr      = (r.lo > GAP_MIN) ? r.lo : GAP_MIN;
        r.aborted = 0;
        r.abort_k = 0;
        exp_q.push_back(r);
        m_active = 1;
        m_end    = k + total_len(r) + 1;
      end
    end else if (a) begin
      r = exp_q.pop_back();
      r.aborted = 1;
      r.abort_k = k;
      exp_q.push_back(r);
      m_active = 0;
    end
  endtask

  bit cap[$];
  bit prev_busy = 0;

  always @(negedge clk) begin
    rec_t r;
    int   exp_len;
    int   exp_end;
    int   bad;
    if (!rst_n) begin
      cap.delete();
      prev_busy = 0;
    end else begin
      if (o_busy) cap.push_back(o_a_out);
      if (o_done || (prev_busy && !o_busy)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          r = exp_q.pop_front();
          if (r.aborted) begin
            exp_len = r.abort_k - r.t;
            exp_end = r.abort_k + 1;
            chk("abort_no_done", o_done, 0);
          end else begin
            exp_len = total_len(r);
            exp_end = r.t + exp_len + 1;
            chk("done", o_done, 1);
          end
          chk("end_cycle", cyc, exp_end);
          chk("wave_len", cap.size(), exp_len);
          bad = 0;
          for (int i = 0; i < cap.size() && i < exp_len; i++)
            if (cap[i] != wave_bit(r, i)) bad++;
          chk("wave_bits_wrong", bad, 0);
          chk("a_out_at_end", o_a_out, 0);
        end
        cap.delete();
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    i_start  = 0;
    i_abort  = 0;
    i_hi_len = '0;
    i_lo_len = '0;
    rst_n    = 0;
    #22;
    chk("reset_a_out", o_a_out, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    @(posedge clk);
    #2 rst_n = 1;

    // hi=3, lo=2
    step(1, 0, 3, 2);
    repeat (12) step(0, 0, 3, 2);

    // zero lengths collapse to single-cycle phases
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // start held high: back-to-back patterns
    repeat (40) step(1, 0, 2, 2);
    repeat (10) step(0, 0, 0, 0);

    // start pulses and length changes while busy
    step(1, 0, 3, 3);
    repeat (14) step(1'($urandom_range(0, 1)), 0, $urandom_range(0, 9), 3);
    repeat (20) step(0, 0, 0, 0);

    // abort during HI2 with hi=4, lo=4
    step(1, 0, 4, 4);
    repeat (9) step(0, 0, 4, 4);
    step(0, 1, 4, 4);
    repeat (5) step(0, 0, 0, 0);

    // abort together with start in IDLE drops the start
    step(1, 1, 2, 2);
    repeat (10) step(0, 0, 0, 0);

    // reset during LO1, then a clean pattern
    step(1, 0, 3, 4);
    repeat (4) step(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_a_out", o_a_out, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    m_active = 0;
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    step(1, 0, 3, 4);
    repeat (16) step(0, 0, 0, 0);

    // random traffic
    repeat (400)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
           $urandom_range(0, 5), $urandom_range(0, 5));

    // drain outstanding patterns with a cycle budget
    i_start = 0;
    i_abort = 0;
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
